// File: rtl/fsm_input_sequencer_if.sv
// rtl/fsm_input_sequencer_if.sv - host and async-circuit signal bundle for fsm_input_sequencer
interface fsm_input_sequencer_if #(
   parameter int ZCNT_W = 4
);
   logic              start;
   logic [15:0]       pattern;
   logic [2:0]        len;
   logic              z_in;
   logic              x2;
   logic              x1;
   logic              busy;
   logic              done;
   logic [7:0]        z_trace;
   logic [ZCNT_W-1:0] z_count;

   modport master (
      output start, pattern, len, z_in,
      input  x2, x1, busy, done, z_trace, z_count
   );

   modport slave (
      input  start, pattern, len, z_in,
      output x2, x1, busy, done, z_trace, z_count
   );
endinterface

// File: rtl/fsm_input_sequencer.sv
// rtl/fsm_input_sequencer.sv - one-bit-per-edge {x2,x1} stimulus sequencer with settle/sample of z
// Optional SEQ_LOOP_EN: adds stop input and repeats the pattern until stop is seen.
module fsm_input_sequencer #(
   parameter int SETTLE_CYCLES = 4,
   parameter int ZCNT_W        = 4
) (
   input logic                  clk,
   input logic                  rst,
`ifdef SEQ_LOOP_EN
   input logic                  stop,
`endif
   fsm_input_sequencer_if.slave bus
);
   localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
   localparam logic [ZCNT_W-1:0] ZCNT_MAX    = '1;

   typedef enum logic [2:0] {IDLE, STEP1, STEP2, SETTLE, SAMPLE, DONE} state_t;

   state_t            state_q, state_d;
   logic [1:0]        x_q, x_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic              half_q, half_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [15:0]       pat_q, pat_d;
   logic [2:0]        len_q, len_d;
   logic [7:0]        trace_q, trace_d;
   logic [ZCNT_W-1:0] zcnt_q, zcnt_d;
   logic [2:0]        zsync_q, zsync_d;
`ifdef SEQ_LOOP_EN
   logic              stop_seen_q, stop_seen_d;
`endif

   logic       z_s, z_prev;
   logic [2:0] nxt_idx;
   logic [1:0] cur_sym, nxt_sym;

   function automatic logic [1:0] sym_at(input logic [15:0] p, input logic [2:0] i);
      return p[{i, 1'b0} +: 2];
   endfunction

   // First SETTLE_CYCLES-1 edges after an issue are spent in SETTLE unless S==1.
   function automatic state_t after_issue(input logic h);
      if (SETTLE_CYCLES == 1) return h ? STEP2 : SAMPLE;
      return SETTLE;
   endfunction

   assign z_s     = zsync_q[1];
   assign z_prev  = zsync_q[2];
   assign nxt_idx = idx_q + 3'd1;
   assign cur_sym = sym_at(pat_q, idx_q);
   assign nxt_sym = sym_at(pat_q, nxt_idx);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      half_d  = half_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pat_d   = pat_q;
      len_d   = len_q;
      trace_d = trace_q;
      zcnt_d  = zcnt_q;
      zsync_d = {zsync_q[1:0], bus.z_in};
`ifdef SEQ_LOOP_EN
      stop_seen_d = stop_seen_q | (busy_q & stop);
`endif

      if (busy_q && z_s && !z_prev && (zcnt_q != ZCNT_MAX))
         zcnt_d = zcnt_q + ZCNT_W'(1);

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               pat_d   = bus.pattern;
               len_d   = bus.len;
               trace_d = '0;
               zcnt_d  = '0;
               busy_d  = 1'b1;
               idx_d   = 3'd0;
               state_d = (&(x_q ^ bus.pattern[1:0])) ? STEP1 : STEP2;
`ifdef SEQ_LOOP_EN
               stop_seen_d = 1'b0;
`endif
            end
         end
         STEP1: begin
            x_d[0]  = cur_sym[0];
            half_d  = 1'b1;
            cnt_d   = SETTLE_LOAD;
            state_d = after_issue(1'b1);
         end
         STEP2: begin
            x_d     = cur_sym;
            half_d  = 1'b0;
            cnt_d   = SETTLE_LOAD;
            state_d = after_issue(1'b0);
         end
         SETTLE: begin
            if (cnt_q == '0) state_d = half_q ? STEP2 : SAMPLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         SAMPLE: begin
            trace_d[idx_q] = z_s;
            if (idx_q == len_q) begin
               state_d = DONE;
            end else begin
               idx_d   = nxt_idx;
               state_d = (&(x_q ^ nxt_sym)) ? STEP1 : STEP2;
            end
         end
         DONE: begin
            done_d = 1'b1;
`ifdef SEQ_LOOP_EN
            if (stop_seen_q) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               // Wrap issues symbol 0 on the done edge so pass timing stays uniform.
               idx_d = 3'd0;
               if (&(x_q ^ pat_q[1:0])) begin
                  x_d[0] = pat_q[0];
                  half_d = 1'b1;
               end else begin
                  x_d    = pat_q[1:0];
                  half_d = 1'b0;
               end
               cnt_d   = SETTLE_LOAD;
               state_d = after_issue(half_d);
            end
`else
            busy_d  = 1'b0;
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= 2'b00;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         half_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pat_q   <= 16'h0000;
         len_q   <= 3'd0;
         trace_q <= 8'h00;
         zcnt_q  <= '0;
         zsync_q <= 3'b000;
`ifdef SEQ_LOOP_EN
         stop_seen_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         half_q  <= half_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         trace_q <= trace_d;
         zcnt_q  <= zcnt_d;
         zsync_q <= zsync_d;
`ifdef SEQ_LOOP_EN
         stop_seen_q <= stop_seen_d;
`endif
      end
   end

   assign bus.x2      = x_q[1];
   assign bus.x1      = x_q[0];
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.z_trace = trace_q;
   assign bus.z_count = zcnt_q;
endmodule
